// File: rtl/tone_map_nch_if.sv
// tone_map_nch pixel stream bundle: input pixels and strobes, delayed output.
// master drives *_i and reads *_o; slave is the tone mapper side.
interface tone_map_nch_if #(
  parameter int W  = 10,
  parameter int WO = 8,
  parameter int CH = 3
);
  logic              sop_i;
  logic              eop_i;
  logic              valid_i;
  logic [CH*W-1:0]   data_i;
  logic [CH*WO-1:0]  data_o;
  logic              sop_o;
  logic              eop_o;
  logic              valid_o;
  logic              mode_o;

  modport master (
    output sop_i, eop_i, valid_i, data_i,
    input  data_o, sop_o, eop_o, valid_o, mode_o
  );

  modport slave (
    input  sop_i, eop_i, valid_i, data_i,
    output data_o, sop_o, eop_o, valid_o, mode_o
  );
endinterface

// File: rtl/tone_map_nch.sv
// N-channel tone mapper: per-frame auto-exposure shift plus knee compressor.
// Ports: clk, reset, enable, reg_knee, reg_slope_sh, frame_shift_o, st (stream).
module tone_map_nch #(
  parameter int W  = 10,
  parameter int WO = 8,
  parameter int CH = 3,
  parameter int SW = $clog2(W-WO+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [WO-1:0] reg_knee,
  input  logic [3:0]    reg_slope_sh,
  output logic [SW-1:0] frame_shift_o,
  tone_map_nch_if.slave st
);
  localparam int DS = W - WO;
  localparam logic [WO-1:0] OMAX = '1;
  localparam logic [W-1:0]  OMAXW = {{DS{1'b0}}, OMAX};

  logic          mode_q;
  logic          in_frame;
  logic [W-1:0]  run_max;
  logic [SW-1:0] exp_shift;
  logic [SW-1:0] frame_sh;
  logic [W-1:0]  pmax;
  logic [W-1:0]  fmax;
  logic [SW-1:0] new_shift;
  logic          start;

  assign start = st.valid_i & st.sop_i;
  assign frame_shift_o = exp_shift;

  always_comb begin
    pmax = '0;
    for (int k = 0; k < CH; k++)
      if (st.data_i[k*W +: W] > pmax)
        pmax = st.data_i[k*W +: W];
  end

  // A sop pixel starts a fresh maximum, even if it is also the eop.
  always_comb begin
    fmax = pmax;
    if (!st.sop_i && run_max > pmax)
      fmax = run_max;
  end

  // Smallest shift that brings the frame peak into output range.
  always_comb begin
    new_shift = SW'(DS);
    for (int i = DS; i >= 0; i--)
      if ((fmax >> i) <= OMAXW)
        new_shift = SW'(i);
  end

  // Mode and frame shift are frozen at sop; an eop only arms the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= 1'b0;
      in_frame  <= 1'b0;
      run_max   <= '0;
      exp_shift <= SW'(DS);
      frame_sh  <= SW'(DS);
    end else begin
      if (start) begin
        mode_q   <= enable;
        frame_sh <= exp_shift;
        run_max  <= pmax;
        in_frame <= 1'b1;
      end else if (st.valid_i && in_frame) begin
        run_max  <= fmax;
      end
      if (st.valid_i && st.eop_i && (st.sop_i || in_frame)) begin
        exp_shift <= new_shift;
        in_frame  <= 1'b0;
      end
    end
  end

  logic              v1, s1, e1, m1;
  logic [CH*W-1:0]   d1;
  logic [SW-1:0]     sh1;
  logic              v2, s2, e2, m2;
  logic [CH*WO-1:0]  d2;
  logic [CH*WO-1:0]  d2_n;
  logic [CH*WO-1:0]  d3_n;

  always_comb begin
    logic [W-1:0]  xs;
    logic [WO-1:0] y;
    d2_n = '0;
    for (int k = 0; k < CH; k++) begin
      xs = d1[k*W +: W] >> sh1;
      y  = (|xs[W-1:WO]) ? OMAX : xs[WO-1:0];
      d2_n[k*WO +: WO] = m1 ? y : d1[k*W+W-1 -: WO];
    end
  end

  // Above the knee the excess is attenuated; result never exceeds y.
  always_comb begin
    logic [WO-1:0] y3;
    d3_n = '0;
    for (int k = 0; k < CH; k++) begin
      y3 = d2[k*WO +: WO];
      if (m2 && y3 > reg_knee)
        d3_n[k*WO +: WO] = reg_knee + ((y3 - reg_knee) >> reg_slope_sh);
      else
        d3_n[k*WO +: WO] = y3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0; s1 <= 1'b0; e1 <= 1'b0; m1 <= 1'b0;
      d1 <= '0;   sh1 <= '0;
      v2 <= 1'b0; s2 <= 1'b0; e2 <= 1'b0; m2 <= 1'b0;
      d2 <= '0;
      st.valid_o <= 1'b0;
      st.sop_o   <= 1'b0;
      st.eop_o   <= 1'b0;
      st.mode_o  <= 1'b0;
      st.data_o  <= '0;
    end else begin
      v1  <= st.valid_i;
      s1  <= st.valid_i & st.sop_i;
      e1  <= st.valid_i & st.eop_i;
      m1  <= start ? enable : mode_q;
      sh1 <= start ? exp_shift : frame_sh;
      d1  <= st.data_i;
      v2  <= v1; s2 <= s1; e2 <= e1; m2 <= m1;
      d2  <= d2_n;
      st.valid_o <= v2;
      st.sop_o   <= s2;
      st.eop_o   <= e2;
      st.mode_o  <= m2;
      st.data_o  <= d3_n;
    end
  end
endmodule

// File: tb/tb_tone_map_nch.sv
// Self-checking bench for tone_map_nch with a frame-level reference model.
// Directed scenarios followed by randomized frames.
module tb_tone_map_nch;
  localparam int W  = 10;
  localparam int WO = 8;
  localparam int CH = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [WO-1:0] reg_knee;
  logic [3:0]    reg_slope_sh;
  logic [SW-1:0] frame_shift_o;

  tone_map_nch_if #(.W(W), .WO(WO), .CH(CH)) bus ();

  tone_map_nch #(.W(W), .WO(WO), .CH(CH)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .reg_knee(reg_knee),
    .reg_slope_sh(reg_slope_sh),
    .frame_shift_o(frame_shift_o),
    .st(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               v;
    bit               s;
    bit               e;
    bit               m;
    logic [CH*WO-1:0] d;
  } exp_t;

  exp_t q[$];
  exp_t ex;
  int   n_cmp = 0;
  int   n_bad = 0;

  bit m_mode;
  bit m_in;
  int m_run;
  int m_exp;
  int m_fsh;

  function automatic int ref_shift(int f);
    int s = 0;
    while ((f >> s) > 255) s++;
    return s;
  endfunction

  task automatic model_reset();
    exp_t z;
    z.v = 0; z.s = 0; z.e = 0; z.m = 0; z.d = '0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
    m_mode = 0; m_in = 0; m_run = 0; m_exp = 2; m_fsh = 2;
  endtask

  task automatic model(bit v, bit s, bit e, logic [CH*W-1:0] d);
    exp_t r;
    int pm, fm, x, y;
    r.v = v; r.s = v & s; r.e = v & e; r.m = 0; r.d = '0;
    if (v) begin
      pm = 0;
      for (int k = 0; k < CH; k++) begin
        x = int'(d[k*W +: W]);
        if (x > pm) pm = x;
      end
      if (s) begin
        m_mode = enable;
        m_fsh  = m_exp;
      end
      r.m = m_mode;
      for (int k = 0; k < CH; k++) begin
        x = int'(d[k*W +: W]);
        if (!m_mode) y = x / 4;
        else begin
          y = x >> m_fsh;
          if (y > 255) y = 255;
          if (y > int'(reg_knee))
            y = int'(reg_knee) + ((y - int'(reg_knee)) >> reg_slope_sh);
        end
        r.d[k*WO +: WO] = 8'(y);
      end
      fm = s ? pm : (m_run > pm ? m_run : pm);
      if (s) begin m_run = pm; m_in = 1; end
      else if (m_in) m_run = fm;
      if (e && m_in) begin
        m_exp = ref_shift(fm);
        m_in  = 0;
      end
    end
    q.push_back(r);
  endtask

  task automatic step(bit v, bit s, bit e, logic [CH*W-1:0] d);
    bus.valid_i = v;
    bus.sop_i   = s;
    bus.eop_i   = e;
    bus.data_i  = d;
    model(v, s, e, d);
    @(posedge clk);
    #1;
    ex = q.pop_front();
    bus.valid_i = 0;
    bus.sop_i   = 0;
    bus.eop_i   = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++)
      step(1, i == 0, i == 3, CH*W'($urandom));
    #2 reset = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({bus.data_o, bus.valid_o, bus.sop_o, bus.eop_o, bus.mode_o,
           frame_shift_o} !== {24'h0, 4'b0000, 2'd2}) begin
        n_bad++;
        $display("FAIL reset_hold got data=%h v=%b sh=%0d need 0/0/2",
                 bus.data_o, bus.valid_o, frame_shift_o);
      end
      @(posedge clk);
      #1;
    end
    model_reset();
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      n_cmp++;
      if (bus.valid_o !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_stray_valid got=%b need=0", bus.valid_o);
      end
    end
  endtask

  task automatic test_bypass();
    enable = 0;
    step(1, 1, 0, {10'h3FF, 10'h200, 10'h004});
    idle(2);
    n_cmp++;
    if ({bus.data_o, bus.valid_o, bus.sop_o, bus.mode_o} !==
        {8'hFF, 8'h80, 8'h01, 3'b110}) begin
      n_bad++;
      $display("FAIL bypass got d=%h v=%b s=%b m=%b need ff8001/1/1/0",
               bus.data_o, bus.valid_o, bus.sop_o, bus.mode_o);
    end
  endtask

  task automatic test_auto_exposure();
    enable = 1; reg_knee = 8'hFF; reg_slope_sh = 0;
    step(1, 1, 0, {3{10'h0C8}});
    step(1, 0, 0, {10'h0F0, 10'h000, 10'h000});
    step(1, 0, 1, {3{10'h010}});
    n_cmp++;
    if ({bus.data_o, bus.mode_o, bus.sop_o} !== {{3{8'h32}}, 2'b11}) begin
      n_bad++;
      $display("FAIL ae_frame1 got d=%h m=%b s=%b need 323232/1/1",
               bus.data_o, bus.mode_o, bus.sop_o);
    end
    n_cmp++;
    if (frame_shift_o !== 2'd0) begin
      n_bad++;
      $display("FAIL ae_shift got=%0d need=0", frame_shift_o);
    end
    step(1, 1, 0, {3{10'h0C8}});
    step(1, 0, 1, {3{10'h0C8}});
    idle(1);
    n_cmp++;
    if (bus.data_o !== {3{8'hC8}}) begin
      n_bad++;
      $display("FAIL ae_frame2 got=%h need=c8c8c8", bus.data_o);
    end
    idle(2);
  endtask

  task automatic test_knee();
    reg_knee = 8'h80; reg_slope_sh = 2;
    step(1, 1, 0, {10'h0C0, 10'h100, 10'h050});
    idle(2);
    n_cmp++;
    if (bus.data_o !== {8'h90, 8'h9F, 8'h50}) begin
      n_bad++;
      $display("FAIL knee got=%h need=909f50", bus.data_o);
    end
  endtask

  task automatic test_truncated();
    step(1, 1, 0, {10'h3FF, 10'h000, 10'h000});
    step(1, 0, 0, {3{10'h020}});
    step(1, 1, 0, {3{10'h010}});
    idle(1);
    n_cmp++;
    if (frame_shift_o !== 2'd0) begin
      n_bad++;
      $display("FAIL trunc_shift got=%0d need=0", frame_shift_o);
    end
    step(1, 1, 1, {10'h1FF, 10'h010, 10'h020});
    n_cmp++;
    if (frame_shift_o !== 2'd1) begin
      n_bad++;
      $display("FAIL single_px_shift got=%0d need=1", frame_shift_o);
    end
    step(1, 0, 1, {3{10'h3FF}});
    idle(1);
    n_cmp++;
    if (frame_shift_o !== 2'd1) begin
      n_bad++;
      $display("FAIL stray_eop_shift got=%0d need=1", frame_shift_o);
    end
    idle(3);
  endtask

  task automatic test_mode_boundary();
    int cin, cout;
    bit v, s, e;
    cin = 0; cout = 0;
    reg_knee = 8'hFF; reg_slope_sh = 0; enable = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 4) enable = 1;
      v = (i != 8) && (i < 12);
      s = (i == 0) || (i == 9);
      e = (i == 7) || (i == 11);
      if (v) cin++;
      step(v, s, e, CH*W'({$urandom, $urandom}));
      if (bus.valid_o === 1'b1) cout++;
      n_cmp++;
      if (bus.valid_o !== ex.v ||
          (ex.v && {bus.data_o, bus.sop_o, bus.eop_o, bus.mode_o} !==
                   {ex.d, ex.s, ex.e, ex.m})) begin
        n_bad++;
        $display("FAIL mode_bnd i=%0d got v=%b d=%h s=%b e=%b m=%b need %b %h %b %b %b",
                 i, bus.valid_o, bus.data_o, bus.sop_o, bus.eop_o, bus.mode_o,
                 ex.v, ex.d, ex.s, ex.e, ex.m);
      end
    end
    n_cmp++;
    if (cout !== cin) begin
      n_bad++;
      $display("FAIL mode_bnd_count got=%0d need=%0d", cout, cin);
    end
  endtask

  task automatic test_random();
    bit v, s, e;
    int top;
    logic [CH*W-1:0] d;
    top = 1023;
    for (int r = 0; r < 3; r++) begin
      idle(3);
      reg_knee = 8'($urandom_range(0, 255));
      reg_slope_sh = 4'($urandom_range(0, 15));
      for (int c = 0; c < 500; c++) begin
        v = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 11) == 0);
        e = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 19) == 0) enable = ~enable;
        if (v && s) begin
          case ($urandom_range(0, 2))
            0: top = 255;
            1: top = 511;
            default: top = 1023;
          endcase
        end
        for (int k = 0; k < CH; k++)
          d[k*W +: W] = W'($urandom_range(0, top));
        step(v, s, e, d);
        n_cmp++;
        if (bus.valid_o !== ex.v ||
            (ex.v && {bus.data_o, bus.sop_o, bus.eop_o, bus.mode_o} !==
                     {ex.d, ex.s, ex.e, ex.m})) begin
          n_bad++;
          $display("FAIL rand r=%0d c=%0d got v=%b d=%h s=%b e=%b m=%b need %b %h %b %b %b",
                   r, c, bus.valid_o, bus.data_o, bus.sop_o, bus.eop_o,
                   bus.mode_o, ex.v, ex.d, ex.s, ex.e, ex.m);
        end
        n_cmp++;
        if (int'(frame_shift_o) !== m_exp) begin
          n_bad++;
          $display("FAIL rand_shift r=%0d c=%0d got=%0d need=%0d",
                   r, c, frame_shift_o, m_exp);
        end
      end
    end
  endtask

  initial begin
    reset = 1;
    enable = 0;
    reg_knee = 8'hFF;
    reg_slope_sh = 0;
    bus.valid_i = 0;
    bus.sop_i = 0;
    bus.eop_i = 0;
    bus.data_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    test_reset();
    test_bypass();
    test_auto_exposure();
    test_knee();
    test_truncated();
    test_mode_boundary();
    test_random();
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tone_map_nch.md
# tone_map_nch

Parametrised N-channel tone-mapping stage between the HDR merge and the 8-bit video output path. It converts CH packed channels of W-bit linear pixels into WO-bit output. It applies a per-frame auto-exposure shift derived from the previous frame's peak, followed by a programmable knee compressor. Bypass and tone-mapped modes share one fixed-latency pipeline, and a mode change takes effect only on a frame boundary.

## Interface
Parameters:
- W, 10: input channel width.
- WO, 8: output channel width; W > WO is required.
- CH, 3: channel count; channel k occupies bits [k*W +: W] in and [k*WO +: WO] out.
- SW, $clog2(W-WO+1): width of the exposure shift.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  mode request: 1 = tone map, 0 = bypass.
- reg_knee  in  WO  knee point, in the output domain.
- reg_slope_sh  in  4  right-shift applied above the knee.
- sop_i, eop_i, valid_i  in  1 each  frame strobes, qualified by valid_i.
- data_i  in  CH*W  packed input pixels.
- data_o  out  CH*WO  packed output pixels.
- sop_o, eop_o, valid_o  out  1 each  delayed strobes.
- mode_o  out  1  mode in force for the pixel on data_o.
- frame_shift_o  out  SW  exposure shift currently armed for the next frame.

## Operation
- **Mode latch.** mode_q captures enable on each cycle where valid_i && sop_i. That pixel and the rest of its frame use the new value. Toggling enable mid-frame has no effect. After reset, mode is bypass until the first sop.
- **Bypass path.** Each channel outputs x[W-1 -: WO], i.e. x >> (W-WO).
- **Statistics.** pmax is the maximum over channels of the current valid pixel.
  - On valid && sop: run_max <= pmax and in_frame <= 1.
  - On any other valid pixel while in_frame: run_max <= max(run_max, pmax).
  - On valid && eop while in_frame:
    - fmax = max(run_max, pmax); when sop and eop coincide, fmax = pmax.
    - exp_shift <= the smallest s in 0..W-WO with (fmax >> s) <= 2^WO-1.
    - in_frame <= 0.
  - Eop while not in_frame is ignored.
  - A sop while in_frame (truncated frame) discards run_max and leaves exp_shift unchanged.
  - Statistics are gathered in both modes.
- **Tone path (per channel).**
  - y = x >> exp_shift, saturated to 2^WO-1.
  - z = y if y <= reg_knee, else reg_knee + ((y - reg_knee) >> reg_slope_sh).
  - z never exceeds y, so no final clamp is needed.
- **Shift timing.** A pixel uses the exp_shift registered before its own sop cycle. An eop update therefore applies from the next frame.
- **No backpressure.** The pipeline runs every cycle. data_o is meaningful only when valid_o = 1.

## Timing
- Latency is exactly 3 cycles in both modes for data_o, sop_o, eop_o, valid_o and mode_o. A mode change never adds, drops or duplicates a pixel.
  - Stage 1: register data, strobes, effective mode and exp_shift.
  - Stage 2: shift and saturate; bypass select.
  - Stage 3: knee compressor; output register.
- Reset values:
  - data_o = 0; sop_o, eop_o, valid_o = 0; mode_o = 0.
  - frame_shift_o = W-WO; exp_shift = W-WO; run_max = 0; in_frame = 0.
- Reset mid-frame clears the pipeline immediately. No output strobes appear for pixels that were in flight.
- reg_knee and reg_slope_sh are sampled in stage 3 without frame-boundary alignment. Software changes them during blanking.
- frame_shift_o updates the cycle after the qualifying eop.

## Test plan
All scenarios use W=10, WO=8, CH=3.
1. **Reset.** Assert reset mid-stream -> all outputs 0 and frame_shift_o = 2 while reset is held. No stray valid_o after release.
2. **Bypass.** enable=0, pixel {0x3FF, 0x200, 0x004} with sop -> 3 cycles later data_o = {0xFF, 0x80, 0x01}, sop_o=1, mode_o=0.
3. **Auto exposure.** enable=1, reg_knee=0xFF.
   - Frame 1 has peak 0x0F0; its pixel 0x0C8 outputs 0x32 (shift 2).
   - After frame 1's eop, frame_shift_o = 0.
   - In frame 2, pixel 0x0C8 outputs 0xC8.
4. **Knee.** exp_shift=0, reg_knee=0x80, reg_slope_sh=2.
   - Input 0x0C0 -> 0x90.
   - Input 0x100 -> saturates to 0xFF -> 0x9F.
   - Input 0x050 -> 0x50.
5. **Mode boundary.** Toggle enable from 0 to 1 mid-frame -> the rest of the frame stays bypass (mode_o=0). The next sop pixel and onward show mode_o=1. valid_o count equals valid_i count and latency stays 3 throughout.
6. **Truncated and degenerate frames.**
   - Sop with peak 0x3FF, then a second sop without eop -> frame_shift_o unchanged.
   - A single-pixel frame with sop=eop=1 and peak 0x1FF -> frame_shift_o = 1.
